// File: rtl/ddc_edid_pkg.sv
// Shared types and constants for the DDC/EDID read master.
package ddc_edid_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_DEV_W, ST_ACK_DW, ST_WADDR, ST_ACK_WA, ST_RSTART,
        ST_DEV_R, ST_ACK_DR, ST_RDATA, ST_MACK, ST_STOP, ST_DONE
    } state_t;

    localparam logic [6:0] DDC_DEV_ADDR   = 7'h50;
    localparam logic [1:0] Q0             = 2'd0;
    localparam logic [1:0] Q1             = 2'd1;
    localparam logic [1:0] Q2             = 2'd2;
    localparam logic [1:0] Q3             = 2'd3;
    localparam int         EDID_BLOCK_LEN = 128;

endpackage

// File: rtl/i2c_qtr_timer.sv
// SCL quarter-bit timer: tick on the last cycle of each quarter, frozen while
// the slave stretches SCL.
module i2c_qtr_timer
    import ddc_edid_pkg::*;
#(
    parameter int P_QTR_DIV = 250
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_run,
    input  logic       i_hold,
    output logic       o_tick,
    output logic [1:0] o_qtr
);
    localparam int            CW      = $clog2(P_QTR_DIV);
    localparam logic [CW-1:0] LP_LAST = CW'(P_QTR_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_qtr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_run) begin
            r_cnt <= '0;
            r_qtr <= Q0;
        end else if (!i_hold) begin
            if (r_cnt == LP_LAST) begin
                r_cnt <= '0;
                r_qtr <= r_qtr + 2'd1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_tick = i_run & ~i_hold & (r_cnt == LP_LAST);
    assign o_qtr  = r_qtr;

endmodule

// File: rtl/ddc_edid_master.sv
// DDC master: random-read of N EDID bytes from a sink, each byte presented
// on a write strobe for a shadow RAM.
module ddc_edid_master
    import ddc_edid_pkg::*;
#(
    parameter int         P_QTR_DIV  = 250,
    parameter logic [6:0] P_DEV_ADDR = DDC_DEV_ADDR,
    parameter string      p_debug_en = "FALSE"
) (
    input  logic       i_local_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_word_addr,
    input  logic [8:0] i_rd_len,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack,
    output logic       o_rd_de,
    output logic [7:0] o_rd_addr,
    output logic [7:0] o_rd_data,
    output logic       o_scl,
    input  logic       i_scl,
    output logic       o_sda,
    input  logic       i_sda
);
    localparam bit LP_DBG = (p_debug_en == "TRUE");

    state_t     r_state;
    logic       r_scl, r_sda, r_busy, r_done, r_nack, r_rd_de, r_smp;
    logic [7:0] r_rd_addr, r_rd_data, r_addr, r_shift, r_rx;
    logic [8:0] r_rem;
    logic [2:0] r_bit;
    logic       w_run, w_hold, w_tick;
    logic [1:0] w_qtr;

    assign w_run  = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_hold = r_scl & ~i_scl;

    i2c_qtr_timer #(.P_QTR_DIV(P_QTR_DIV)) u_timer (
        .i_clk   (i_local_clk),
        .i_rst_n (i_rst_n),
        .i_run   (w_run),
        .i_hold  (w_hold),
        .o_tick  (w_tick),
        .o_qtr   (w_qtr)
    );

    // {scl, sda} for quarters q1..q3 of the symbol in progress
    function automatic logic [1:0] mid_lines(input state_t st, input logic [1:0] qn,
                                             input logic sda);
        case (st)
            ST_START, ST_RSTART: return {qn != Q3, qn == Q1};
            ST_STOP:             return {1'b1, qn != Q1};
            default:             return {qn != Q1, sda};
        endcase
    endfunction

    always_ff @(posedge i_local_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_scl     <= 1'b1;
            r_sda     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_nack    <= 1'b0;
            r_rd_de   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_addr    <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_rem     <= '0;
            r_bit     <= '0;
            r_smp     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_rd_de <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!LP_DBG) r_bit <= '0;
                    if (i_start) begin
                        r_addr  <= i_word_addr;
                        r_rem   <= i_rd_len;
                        r_nack  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= (i_rd_len == '0) ? ST_DONE : ST_START;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: if (w_tick) begin
                    if (w_qtr == Q2) begin
                        r_smp <= i_sda;
                        if (r_state == ST_RDATA) begin
                            r_rx <= {r_rx[6:0], i_sda};
                            if (r_bit == 3'd7) begin
                                r_rd_de   <= 1'b1;
                                r_rd_data <= {r_rx[6:0], i_sda};
                                r_rd_addr <= r_addr;
                                r_addr    <= r_addr + 8'd1;
                                r_rem     <= r_rem - 9'd1;
                            end
                        end
                    end
                    if (w_qtr != Q3) begin
                        {r_scl, r_sda} <= mid_lines(r_state, w_qtr + 2'd1, r_sda);
                    end else begin
                        // symbol boundary: pick next symbol and drive its q0
                        r_scl <= 1'b0;
                        case (r_state)
                            ST_START, ST_RSTART: begin
                                r_state <= (r_state == ST_START) ? ST_DEV_W : ST_DEV_R;
                                r_shift <= {P_DEV_ADDR, r_state == ST_RSTART};
                                r_sda   <= P_DEV_ADDR[6];
                                r_bit   <= '0;
                            end
                            ST_DEV_W, ST_WADDR, ST_DEV_R: begin
                                if (r_bit == 3'd7) begin
                                    r_state <= (r_state == ST_DEV_W) ? ST_ACK_DW :
                                               (r_state == ST_WADDR) ? ST_ACK_WA : ST_ACK_DR;
                                    r_sda   <= 1'b1;
                                end else begin
                                    r_bit   <= r_bit + 3'd1;
                                    r_shift <= {r_shift[6:0], 1'b0};
                                    r_sda   <= r_shift[6];
                                end
                            end
                            ST_ACK_DW, ST_ACK_WA, ST_ACK_DR: begin
                                if (r_smp) begin
                                    r_state <= ST_STOP;
                                    r_nack  <= 1'b1;
                                    r_sda   <= 1'b0;
                                end else if (r_state == ST_ACK_DW) begin
                                    r_state <= ST_WADDR;
                                    r_shift <= r_addr;
                                    r_sda   <= r_addr[7];
                                    r_bit   <= '0;
                                end else if (r_state == ST_ACK_WA) begin
                                    r_state <= ST_RSTART;
                                    r_scl   <= r_scl;
                                    r_sda   <= 1'b1;
                                end else begin
                                    r_state <= ST_RDATA;
                                    r_sda   <= 1'b1;
                                    r_bit   <= '0;
                                end
                            end
                            ST_RDATA: begin
                                if (r_bit == 3'd7) begin
                                    r_state <= ST_MACK;
                                    r_sda   <= (r_rem == '0);
                                end else begin
                                    r_bit <= r_bit + 3'd1;
                                    r_sda <= 1'b1;
                                end
                            end
                            ST_MACK: begin
                                r_state <= (r_rem != '0) ? ST_RDATA : ST_STOP;
                                r_sda   <= (r_rem != '0);
                                r_bit   <= '0;
                            end
                            ST_STOP: begin
                                r_state <= ST_DONE;
                                r_scl   <= 1'b1;
                                r_sda   <= 1'b1;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign o_scl     = r_scl;
    assign o_sda     = r_sda;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_nack    = r_nack;
    assign o_rd_de   = r_rd_de;
    assign o_rd_addr = r_rd_addr;
    assign o_rd_data = r_rd_data;

endmodule

// File: doc/ddc_edid_master.md
Name: ddc_edid_master

Overview:
- I2C/DDC master that reads EDID bytes from a sink monitor at device 7'h50.
- Transaction per request: START, device-write, word offset, repeated START, device-read, N data bytes (master ACK, final byte NACK), STOP.
- Each received byte is presented on a write-style strobe bus, so the bytes can fill an EDID shadow RAM.
- Pairs with the slave side on the same split-SDA (i/o) bus model used in the benches.

Parameters:
- P_QTR_DIV, 250: i_local_clk cycles per SCL quarter-bit (100 kHz at 100 MHz). Minimum 2.
- P_DEV_ADDR, 7'h50: 7-bit DDC device address.
- p_debug_en, "FALSE": "TRUE" preserves state/bit counters for debug. No functional effect.

Ports:
- i_local_clk  in  1  system clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle request pulse. Ignored while o_busy=1.
- i_word_addr  in  8  starting EDID offset, latched on i_start.
- i_rd_len  in  9  number of bytes to read, 0..256, latched on i_start.
- o_busy  out  1  high from the cycle after an accepted i_start until o_done.
- o_done  out  1  one-cycle pulse at end of transaction.
- o_nack  out  1  valid with o_done. 1 means the slave NACKed the device-W, offset or device-R byte.
- o_rd_de  out  1  one-cycle strobe per received byte.
- o_rd_addr  out  8  i_word_addr + byte index, mod 256.
- o_rd_data  out  8  received byte, MSB first on the wire.
- o_scl  out  1  SCL drive. 0 = pull low, 1 = release.
- i_scl  in  1  sampled SCL line, used for stretch detection.
- o_sda  out  1  SDA drive. 0 = pull low, 1 = release.
- i_sda  in  1  sampled SDA line.

Behaviour:
- Reset (sync, i_rst_n=0 at clock edge): state IDLE, o_scl=1, o_sda=1, o_busy=0, o_done=0, o_nack=0, o_rd_de=0, o_rd_addr=0, o_rd_data=0, counters=0.
- Reset mid-transfer aborts immediately and releases both lines. No STOP is generated and no o_done is issued.
- Bit timing: every bus symbol is 4 quarters q0..q3, each P_QTR_DIV cycles long.
  - Data/ACK bit: q0 SCL=0 and SDA set; q1 SCL=0; q2 SCL=1; q3 SCL=1.
  - Sampling: i_sda is sampled in the last cycle of q2.
- Clock stretching: the quarter counter freezes while o_scl=1 and i_scl=0, so a stretched high phase resumes counting only after i_scl is seen high.
- START / RSTART: q0 SDA=1, SCL keeps its previous value; q1 SDA=1, SCL=1; q2 SDA=0, SCL=1; q3 SDA=0, SCL=0.
- STOP: q0 SDA=0, SCL=0; q1 SDA=0, SCL=1; q2 SDA=1, SCL=1; q3 hold.
- FSM states: IDLE, START, DEV_W, ACK_DW, WADDR, ACK_WA, RSTART, DEV_R, ACK_DR, RDATA, MACK, STOP, DONE.
  - Byte states shift 8 bits MSB first.
  - ACK_* states release SDA and sample it.
- Transitions:
  - IDLE, i_start with i_rd_len!=0 -> START.
  - START -> DEV_W, sending {P_DEV_ADDR,0} -> ACK_DW -> WADDR -> ACK_WA -> RSTART -> DEV_R, sending {P_DEV_ADDR,1} -> ACK_DR -> RDATA -> MACK.
  - MACK: drives SDA=0 when bytes remain, SDA=1 (NACK) on the last byte. Then RDATA if bytes remain, else STOP.
  - STOP -> DONE -> IDLE.
- NACK: a sampled SDA=1 in any ACK_* state -> STOP, o_nack=1 latched. o_done then pulses with o_nack=1 and no further o_rd_de.
- Length 0: i_start with i_rd_len=0 produces no bus activity. o_done pulses 2 cycles after i_start with o_nack=0.
- Length 256 reads 256 bytes. o_rd_addr wraps 8'hFF -> 8'h00.
- o_rd_de asserts for one cycle, 1 cycle after the 8th RDATA bit is sampled. o_rd_addr and o_rd_data are valid in that cycle and hold until the next strobe.
- o_busy de-asserts in the same cycle o_done pulses.
- An i_start while o_busy=1 is dropped. An i_start in the o_done cycle is accepted.

Decomposition:
- Package ddc_edid_pkg holds:
  - FSM state localparams.
  - DDC_DEV_ADDR = 7'h50.
  - Quarter indices Q0..Q3.
  - EDID_BLOCK_LEN = 128.
- Sub-module i2c_qtr_timer: divide counter producing a quarter tick and a 2-bit quarter index, with a stretch-hold input (o_scl & ~i_scl).

Test Plan:
- P_QTR_DIV=4, slave model ACKs everything and returns data = offset ^ 8'hA5; start with i_word_addr=8'h00, i_rd_len=128 -> 128 o_rd_de, o_rd_addr 0..127, o_rd_data matches the model, o_done with o_nack=0, wire shows 128 MACK with the last one high (NACK).
- i_word_addr=8'hF0, i_rd_len=32 -> o_rd_addr runs F0..FF then 00..0F, with correct data.
- Slave NACKs the device address -> zero o_rd_de, STOP seen on the wire, o_done with o_nack=1. Repeat with a NACK on the offset byte: same result.
- Slave holds SCL low 37 cycles after each ACK bit -> the transfer stretches by that amount, data is still correct, no quarter shorter than 4 cycles.
- i_rd_len=0 -> o_done 2 cycles after i_start, o_scl/o_sda stay 1 throughout. Second i_start while busy -> ignored, exactly one o_done.
- Sync reset asserted mid-RDATA -> next edge gives o_scl=1, o_sda=1, o_busy=0, no o_done. A new i_start afterwards completes normally.
